// File: rtl/host_word_entry.sv
// Builds the secret word from host letters and hands it to the game FSM.
// Letters shift in from the LSB, so the first letter typed ends up in the MS byte.
//
// state  | meaning
// ENTRY  | collecting letters, backspace and confirm are live
// ARM    | word accepted; start pulse is issued on the way out
// LOCKED | word held for the round until gameEnd
module host_word_entry #(
    parameter int WORD_LEN = 5,
    parameter int CHAR_W   = 8
) (
    input  logic                            clk,
    input  logic                            nRst,
    input  logic [CHAR_W-1:0]               char_in,
    input  logic                            char_strobe,
    input  logic                            del_strobe,
    input  logic                            confirm,
    input  logic                            game_rdy,
    input  logic                            gameEnd,
    output logic [CHAR_W*WORD_LEN-1:0]      setWord,
    output logic                            toggle_state,
    output logic [$clog2(WORD_LEN+1)-1:0]   count,
    output logic                            word_full,
    output logic                            locked,
    output logic                            err
);

    localparam int CW = $clog2(WORD_LEN + 1);
    localparam int WW = CHAR_W * WORD_LEN;
    localparam logic [CW-1:0] FULL_CNT = CW'(WORD_LEN);

    typedef enum logic [1:0] {
        ENTRY  = 2'd0,
        ARM    = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WW-1:0]     word_q, word_d;
    logic [CW-1:0]     count_q, count_d;
    logic              toggle_q, toggle_d;
    logic              locked_q, locked_d;
    logic              err_q, err_d;

    logic              is_upper, is_lower, char_ok;
    logic [CHAR_W-1:0] char_norm;

    always_comb begin
        is_upper  = (char_in >= CHAR_W'(8'h41)) && (char_in <= CHAR_W'(8'h5A));
        is_lower  = (char_in >= CHAR_W'(8'h61)) && (char_in <= CHAR_W'(8'h7A));
        char_ok   = is_upper || is_lower;
        char_norm = is_lower ? (char_in - CHAR_W'(8'h20)) : char_in;
    end

    always_comb begin
        state_d  = state_q;
        word_d   = word_q;
        count_d  = count_q;
        toggle_d = 1'b0;
        locked_d = locked_q;
        err_d    = 1'b0;

        if (gameEnd) begin
            state_d  = ENTRY;
            word_d   = '0;
            count_d  = '0;
            locked_d = 1'b0;
        end else begin
            unique case (state_q)
                ENTRY: begin
                    if (del_strobe) begin
                        if (count_q != '0) begin
                            word_d  = {CHAR_W'(0), word_q[WW-1:CHAR_W]};
                            count_d = count_q - CW'(1);
                        end else begin
                            err_d = 1'b1;
                        end
                    end else if (char_strobe) begin
                        if (!char_ok || count_q == FULL_CNT) begin
                            err_d = 1'b1;
                        end else begin
                            word_d  = {word_q[WW-CHAR_W-1:0], char_norm};
                            count_d = count_q + CW'(1);
                        end
                    end else if (confirm) begin
                        if (count_q == FULL_CNT && game_rdy) begin
                            state_d  = ARM;
                            locked_d = 1'b1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                ARM: begin
                    // Pulse is registered here so a gameEnd in ARM can still cancel it.
                    toggle_d = 1'b1;
                    state_d  = LOCKED;
                    err_d    = del_strobe || char_strobe || confirm;
                end
                LOCKED: begin
                    err_d = del_strobe || char_strobe || confirm;
                end
                default: begin
                    state_d = ENTRY;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q  <= ENTRY;
            word_q   <= '0;
            count_q  <= '0;
            toggle_q <= 1'b0;
            locked_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            word_q   <= word_d;
            count_q  <= count_d;
            toggle_q <= toggle_d;
            locked_q <= locked_d;
            err_q    <= err_d;
        end
    end

    assign setWord      = word_q;
    assign toggle_state = toggle_q;
    assign count        = count_q;
    assign word_full    = (count_q == FULL_CNT);
    assign locked       = locked_q;
    assign err          = err_q;

endmodule

// File: tb/tb_host_word_entry.sv
// Directed bench for host_word_entry: hand-computed words, counts and pulse checks.
module tb_host_word_entry;

    logic        clk = 1'b0;
    logic        nRst = 1'b0;
    logic [7:0]  char_in = '0;
    logic        char_strobe = 1'b0;
    logic        del_strobe = 1'b0;
    logic        confirm = 1'b0;
    logic        game_rdy = 1'b0;
    logic        gameEnd = 1'b0;
    logic [39:0] setWord;
    logic        toggle_state;
    logic [2:0]  count;
    logic        word_full;
    logic        locked;
    logic        err;

    int total = 0;
    int bad   = 0;
    int tog_cnt = 0;
    int tog_dbl = 0;
    logic tog_prev = 1'b0;
    int tog_mark;

    host_word_entry dut (
        .clk         (clk),
        .nRst        (nRst),
        .char_in     (char_in),
        .char_strobe (char_strobe),
        .del_strobe  (del_strobe),
        .confirm     (confirm),
        .game_rdy    (game_rdy),
        .gameEnd     (gameEnd),
        .setWord     (setWord),
        .toggle_state(toggle_state),
        .count       (count),
        .word_full   (word_full),
        .locked      (locked),
        .err         (err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (toggle_state) tog_cnt++;
        if (toggle_state && tog_prev) tog_dbl++;
        tog_prev = toggle_state;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // One clock with the given strobes; returns 1 ns after the edge.
    task automatic cyc(input logic [7:0] c, input logic cs, input logic ds,
                       input logic cf, input logic ge);
        @(negedge clk);
        char_in = c; char_strobe = cs; del_strobe = ds; confirm = cf; gameEnd = ge;
        @(posedge clk);
        #1;
        char_strobe = 1'b0; del_strobe = 1'b0; confirm = 1'b0; gameEnd = 1'b0;
    endtask

    task automatic put(input logic [7:0] c, input logic exp_err);
        cyc(c, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("err_put", err, exp_err);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #2;
        chk("rst_word", setWord, 0);
        chk("rst_count", count, 0);
        chk("rst_toggle", toggle_state, 0);
        chk("rst_locked", locked, 0);
        chk("rst_err", err, 0);
        chk("rst_full", word_full, 0);
        @(negedge clk);
        nRst = 1'b1;

        // lowercase is upper-cased; no errors
        put(8'h68, 0); put(8'h65, 0); put(8'h6C, 0); put(8'h6C, 0);
        chk("hello_full4", word_full, 0);
        put(8'h6F, 0);
        chk("hello_word", setWord, 40'h48454C4C4F);
        chk("hello_count", count, 5);
        chk("hello_full", word_full, 1);

        cyc(8'h00, 0, 0, 0, 1);
        chk("ge_word", setWord, 0);
        chk("ge_count", count, 0);

        // backspace removes the most recent letter
        put(8'h41, 0); put(8'h42, 0); put(8'h43, 0);
        cyc(8'h00, 0, 1, 0, 0);
        chk("del_err", err, 0);
        chk("del_count", count, 2);
        chk("del_word", setWord, 40'h0000004142);
        put(8'h58, 0); put(8'h59, 0); put(8'h5A, 0);
        chk("abxyz_word", setWord, 40'h414258595A);

        cyc(8'h00, 0, 0, 0, 1);
        cyc(8'h00, 0, 1, 0, 0);
        chk("del_empty_err", err, 1);
        chk("del_empty_cnt", count, 0);

        // confirm gating on game_rdy, then hand-off
        put(8'h77, 0); put(8'h6F, 0); put(8'h72, 0); put(8'h64, 0); put(8'h73, 0);
        chk("words_word", setWord, 40'h574F524453);
        tog_mark = tog_cnt;
        game_rdy = 1'b0;
        cyc(8'h00, 0, 0, 1, 0);
        chk("cf_nrdy_err", err, 1);
        chk("cf_nrdy_lock", locked, 0);
        idle(2);
        chk("cf_nrdy_tog", tog_cnt - tog_mark, 0);
        game_rdy = 1'b1;
        cyc(8'h00, 0, 0, 1, 0);
        chk("cf_err", err, 0);
        chk("cf_locked", locked, 1);
        idle(4);
        chk("tog_once", tog_cnt - tog_mark, 1);
        chk("tog_no_dbl", tog_dbl, 0);
        chk("lock_hold", locked, 1);

        // locked: entry attempts rejected, word held
        put(8'h51, 1);
        chk("lk_word_q", setWord, 40'h574F524453);
        cyc(8'h00, 0, 1, 0, 0);
        chk("lk_del_err", err, 1);
        chk("lk_word_d", setWord, 40'h574F524453);
        chk("lk_count", count, 5);
        cyc(8'h00, 0, 0, 0, 1);
        chk("end_word", setWord, 0);
        chk("end_count", count, 0);
        chk("end_locked", locked, 0);
        chk("end_err", err, 0);

        // filter boundaries and overflow
        put(8'h41, 0); put(8'h42, 0);
        put(8'h31, 1); put(8'h00, 1); put(8'h40, 1); put(8'h5B, 1);
        put(8'h60, 1); put(8'h7B, 1);
        chk("filt_word", setWord, 40'h0000004142);
        chk("filt_count", count, 2);
        put(8'h61, 0); put(8'h7A, 0); put(8'h5A, 0);
        chk("full_word", setWord, 40'h4142415A5A);
        put(8'h46, 1);
        chk("ovf_word", setWord, 40'h4142415A5A);
        chk("ovf_count", count, 5);
        cyc(8'h00, 0, 0, 0, 1);

        // simultaneous del + char: only the delete acts
        put(8'h41, 0); put(8'h42, 0); put(8'h43, 0);
        cyc(8'h4B, 1, 1, 0, 0);
        chk("sim_count", count, 2);
        chk("sim_word", setWord, 40'h0000004142);
        chk("sim_err", err, 0);

        // gameEnd beats a char in the same cycle
        cyc(8'h4B, 1, 0, 0, 1);
        chk("ge_pri_count", count, 0);
        chk("ge_pri_word", setWord, 0);

        // reset in ARM aborts the start pulse
        put(8'h4B, 0); put(8'h4C, 0); put(8'h4D, 0); put(8'h4E, 0); put(8'h4F, 0);
        tog_mark = tog_cnt;
        cyc(8'h00, 0, 0, 1, 0);
        chk("arm_locked", locked, 1);
        nRst = 1'b0;
        #1;
        chk("ar_word", setWord, 0);
        chk("ar_count", count, 0);
        chk("ar_toggle", toggle_state, 0);
        chk("ar_locked", locked, 0);
        chk("ar_err", err, 0);
        chk("ar_full", word_full, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("ar_tog_none", tog_cnt - tog_mark, 0);
        nRst = 1'b1;
        idle(2);
        chk("ar_after_tog", tog_cnt - tog_mark, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
